// File: rtl/filter2d_pkg.sv
// Shared types and constants for the filter2d image stream blocks.
package filter2d_pkg;

    // Pixel width of every byte moved over the i_strb/i_data stream.
    localparam int PIX_W = 8;

    // Transmitter sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } tx_state_t;

    // Number of pixels in one frame.
    function automatic int FRAME_PIX(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/img_stream_tx.sv
// Frame-stream transmitter: reads one WIDTH x HEIGHT frame from a sync-read
// memory in raster order and emits it one byte per o_strb pulse, spaced GAP+1.
module img_stream_tx
    import filter2d_pkg::*;
#(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256,
    parameter int ADDR_W = 16,
    parameter int GAP    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              o_strb,
    output logic [PIX_W-1:0]  o_data
);

    // Terminal address is compared on the full frame count, so a frame that
    // exactly fills the address space never relies on counter wrap.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX(WIDTH, HEIGHT) - 1);

    tx_state_t         state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;     // next address to read
    logic              pend_q, pend_d;     // rd_data valid this cycle
    logic              o_strb_q, o_strb_d;
    logic [PIX_W-1:0]  o_data_q, o_data_d;
    logic              gap_last;           // pacing gap has elapsed

    generate
        if (GAP > 0) begin : g_gap
            localparam int GW = $clog2(GAP + 1);
            logic [GW-1:0] gap_q, gap_d;

            // Reload the gap count on every read, count it down while waiting.
            always_comb begin
                gap_d = gap_q;
                if (state_q == READ) begin
                    gap_d = GW'(GAP - 1);
                end else if (state_q == WAIT && gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end
            end

            // Gap counter register.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    gap_q <= '0;
                end else begin
                    gap_q <= gap_d;
                end
            end

            assign gap_last = (gap_q == '0);
        end else begin : g_nogap
            assign gap_last = 1'b1;
        end
    endgenerate

    // Sequencing and data path: read issue, one-cycle capture, registered strobe.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        mem_rd_d  = 1'b0;
        rd_addr_d = rd_addr_q;
        addr_d    = addr_q;
        pend_d    = mem_rd_q;
        o_strb_d  = pend_q;
        o_data_d  = pend_q ? rd_data : o_data_q;

        case (state_q)
            IDLE: begin
                // done_q high means this is the completion cycle: start is dropped.
                if (start && !abort && !done_q) begin
                    state_d   = READ;
                    busy_d    = 1'b1;
                    mem_rd_d  = 1'b1;
                    rd_addr_d = addr_q;
                    addr_d    = addr_q + ADDR_W'(1);
                end
            end
            READ: begin
                if (rd_addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end else if (GAP == 0) begin
                    mem_rd_d  = 1'b1;
                    rd_addr_d = addr_q;
                    addr_d    = addr_q + ADDR_W'(1);
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (gap_last) begin
                    state_d   = READ;
                    mem_rd_d  = 1'b1;
                    rd_addr_d = addr_q;
                    addr_d    = addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                // Last byte is on the output and nothing is left in flight.
                if (!pend_q && o_strb_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    addr_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Cancel drops all in-flight data; o_data keeps the last emitted byte.
        if (abort && state_q != IDLE) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            mem_rd_d = 1'b0;
            pend_d   = 1'b0;
            o_strb_d = 1'b0;
            o_data_d = o_data_q;
            addr_d   = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mem_rd_q  <= 1'b0;
            rd_addr_q <= '0;
            addr_q    <= '0;
            pend_q    <= 1'b0;
            o_strb_q  <= 1'b0;
            o_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            mem_rd_q  <= mem_rd_d;
            rd_addr_q <= rd_addr_d;
            addr_q    <= addr_d;
            pend_q    <= pend_d;
            o_strb_q  <= o_strb_d;
            o_data_q  <= o_data_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign mem_rd  = mem_rd_q;
    assign rd_addr = rd_addr_q;
    assign o_strb  = o_strb_q;
    assign o_data  = o_data_q;

endmodule

// File: doc/img_stream_tx.md
Name: img_stream_tx

Overview:
- Frame-stream transmitter and the source end of the i_strb/i_data byte stream that the input buffer controller receives.
- On start, it reads one WIDTH x HEIGHT 8-bit frame from a synchronous-read memory in raster order and emits one byte per o_strb pulse.
- It inserts a fixed idle gap between bytes and signals frame completion.
- Used as the image source in filter2d benches and as the frame replay path on the SoC side.

Parameters:
- WIDTH, 256, pixels per line
- HEIGHT, 256, lines per frame
- ADDR_W, 16, memory address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT
- GAP, 0, idle cycles between consecutive o_strb pulses (0 = one byte per cycle)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle frame request; ignored while busy
- abort  in  1  synchronous frame cancel
- busy  out  1  high from the cycle after an accepted start until done or abort
- done  out  1  one-cycle pulse after the last byte of a frame
- mem_rd  out  1  memory read enable
- rd_addr  out  ADDR_W  memory read address, valid with mem_rd
- rd_data  in  8  memory read data, valid exactly one cycle after mem_rd
- o_strb  out  1  byte strobe, one cycle per byte
- o_data  out  8  byte, valid while o_strb is high; holds its last value otherwise

Behaviour:
- Reset: every output is 0 (busy, done, mem_rd, rd_addr, o_strb, o_data); FSM enters IDLE; counters are cleared.
- FSM states: IDLE, READ, WAIT, DRAIN.
- IDLE:
  - start=1 and abort=0 at cycle 0 → READ; busy=1 from cycle 1.
- READ:
  - Drive mem_rd=1 and rd_addr=addr for one cycle, then addr increments.
  - GAP=0: stay in READ, issuing back-to-back reads.
  - GAP>0: go to WAIT for GAP cycles, then return to READ.
  - After the read of address WIDTH*HEIGHT-1 → DRAIN.
- DRAIN:
  - Wait for the last in-flight byte to be emitted, then → IDLE.
- Data path:
  - rd_data is captured the cycle after mem_rd.
  - o_strb and o_data are registered, so o_strb appears 2 cycles after the matching mem_rd.
  - Latency: start at cycle 0 → mem_rd at cycle 1 → first o_strb at cycle 3.
  - Strobe spacing is exactly GAP+1 cycles; no backpressure.
- Completion:
  - Total o_strb pulses per frame = WIDTH*HEIGHT, addresses 0..WIDTH*HEIGHT-1 in order.
  - done=1 for one cycle, the cycle after the last o_strb; busy drops in the same cycle.
  - A start coincident with the done cycle is ignored; a start in the following cycle is accepted.
- start while busy: ignored; no restart and no address change.
- abort:
  - Effective when sampled high in any non-IDLE state.
  - Next cycle: busy=0, mem_rd=0, o_strb=0, done stays 0.
  - In-flight data is discarded; addr is reset to 0.
  - abort and start together in IDLE: abort wins, start is dropped.
- Asynchronous reset mid-frame: immediate return to reset values; the next start begins again at address 0.
- Address counter:
  - Counts from 0 to WIDTH*HEIGHT-1; terminal detect is on the full count, not an ADDR_W overflow.
  - rd_addr holds its last value while mem_rd=0.
  - Gap counter width is clog2(GAP+1); no counter is instantiated when GAP=0.

Decomposition:
- Shared package filter2d_pkg holds:
  - the tx_state_t enum (IDLE, READ, WAIT, DRAIN);
  - the PIX_W=8 constant;
  - the FRAME_PIX function (WIDTH*HEIGHT).
- Single module; the address/gap pacing counter is not worth a sub-module.
- The memory is external; benches use the same sync-read RAM model as the receive side.

Test Plan:
- WIDTH=4, HEIGHT=2, GAP=0, mem[i]=i+8'h10, start at cycle 0 → o_strb high for cycles 3..10, o_data 10..17h, done at cycle 11, busy high for cycles 1..10.
- Same frame with GAP=2 → o_strb every 3 cycles starting at cycle 3, 8 pulses total, done the cycle after the 8th pulse, never 2 strobes within 3 cycles.
- start re-pulsed at cycles 4 and 6 mid-frame → identical output to scenario 1, exactly one done.
- abort at cycle 6 (GAP=0) → o_strb=0 and busy=0 from cycle 7, no done; new start at cycle 9 → first o_strb at cycle 12 with o_data=10h.
- Async reset asserted mid-frame for 2 cycles → all outputs 0 immediately; following start replays the full frame from address 0.
- WIDTH=HEIGHT=256 → exactly 65536 strobes, rd_addr ends at FFFFh with no wrap-induced extra read, done once.
